// File: rtl/shift_reg_sequencer_pkg.sv
// Shared datapath mode codes and sequencer states for the shift register sequencer.
package shift_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_SHL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_sequencer_usr_core.sv
// Universal shift register: hold, parallel load, shift toward bit 0, shift toward MSB.
module usr_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_LOAD: q <= d;
        MODE_SHR:  q <= {1'b0, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], 1'b0};
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Serializes parallel words through usr_core, one bit per accepted serial beat.
module shift_reg_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             abort,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);

  state_t           state;
  logic             msb_first;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] core_d;
  logic [IDX_W-1:0] out_idx;

  // Abort in SHIFT clears the register by loading zero; DONE/IDLE already hold zero.
  always_comb begin
    mode   = MODE_HOLD;
    core_d = in_data;
    if (rst) begin
      case (state)
        S_IDLE: begin
          if (in_valid && !abort) mode = MODE_LOAD;
        end
        S_SHIFT: begin
          if (abort) begin
            mode   = MODE_LOAD;
            core_d = '0;
          end else if (ser_ready) begin
            mode = msb_first ? MODE_SHL : MODE_SHR;
          end
        end
        default: mode = MODE_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      msb_first <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state     <= S_SHIFT;
            cnt       <= CNT_W'(WIDTH);
            msb_first <= in_msb_first;
          end
        end
        S_SHIFT: begin
          if (ser_ready) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .d    (core_d),
    .q    (q)
  );

  assign out_idx   = msb_first ? IDX_W'(WIDTH - 1) : '0;
  assign ser_valid = (state == S_SHIFT);
  assign ser_out   = ser_valid & q[out_idx];
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE) && !abort;
  assign bit_cnt   = cnt;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: vector table plus hand-written corner sequences, serial bits scoreboarded.
module tb_shift_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_msb_first = 1'b0;
  logic       abort = 1'b0;
  logic       ser_ready = 1'b0;
  logic [3:0] in_data = 4'b0000;
  logic       in_ready;
  logic       ser_valid;
  logic       ser_out;
  logic [1:0] mode;
  logic [2:0] bit_cnt;
  logic       busy;
  logic       done;

  shift_reg_sequencer #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .abort        (abort),
    .ser_valid    (ser_valid),
    .ser_ready    (ser_ready),
    .ser_out      (ser_out),
    .mode         (mode),
    .bit_cnt      (bit_cnt),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // seq lists the expected serial bits with the first bit out in seq[3].
  typedef struct {
    logic [3:0] data;
    logic       msb;
    logic [3:0] seq;
    logic [1:0] beat_mode;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;
  int   cyc = 0;
  logic exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every accepted serial beat is popped against the expected-bit queue.
  always @(negedge clk) begin : monitor
    logic e;
    if (rst) begin
      if (done) done_count++;
      if (ser_valid && ser_ready && !abort) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL sb_unexpected_bit: got bit %0b with nothing expected (t=%0t)", ser_out, $time);
        end else begin
          e = exp_q.pop_front();
          check_output("sb_ser_out", ser_out, e);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [3:0] seq, input int n);
    for (int i = 3; i > 3 - n; i--) exp_q.push_back(seq[i]);
  endtask

  task automatic apply_stimulus(input logic [3:0] data, input logic msb);
    int k = 0;
    while (!in_ready && k < 20) begin
      next_cycle();
      k++;
    end
    check_output("wait_in_ready", in_ready, 1);
    in_valid     = 1'b1;
    in_data      = data;
    in_msb_first = msb;
    @(negedge clk);
    check_output("load_mode", mode, 2'b01);
    next_cycle();
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    push_seq(v.seq, 4);
    ser_ready = 1'b1;
    apply_stimulus(v.data, v.msb);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("beat_valid", ser_valid, 1);
      check_output("beat_cnt", bit_cnt, 32'(4 - c));
      check_output("beat_mode", mode, v.beat_mode);
      check_output("beat_busy", busy, 1);
      check_output("beat_in_ready", in_ready, 0);
      next_cycle();
    end
    @(negedge clk);
    check_output("done_pulse", done, 1);
    check_output("done_mode", mode, 2'b00);
    check_output("done_cnt", bit_cnt, 0);
    check_output("done_in_ready", in_ready, 0);
    check_output("done_busy", busy, 1);
    next_cycle();
    @(negedge clk);
    check_output("idle_in_ready", in_ready, 1);
    check_output("idle_done", done, 0);
    check_output("idle_busy", busy, 0);
    next_cycle();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs[4];
    int   dc0;
    int   n;
    int   acc[2];

    vecs[0] = '{data: 4'b1101, msb: 1'b0, seq: 4'b1011, beat_mode: 2'b10};
    vecs[1] = '{data: 4'b1101, msb: 1'b1, seq: 4'b1101, beat_mode: 2'b11};
    vecs[2] = '{data: 4'b0110, msb: 1'b1, seq: 4'b0110, beat_mode: 2'b11};
    vecs[3] = '{data: 4'b1000, msb: 1'b0, seq: 4'b0001, beat_mode: 2'b10};

    #12;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_ser_valid", ser_valid, 0);
    check_output("rst_done", done, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_mode", mode, 2'b00);
    check_output("rst_ser_out", ser_out, 0);
    check_output("rst_bit_cnt", bit_cnt, 0);
    next_cycle();
    rst = 1'b1;

    // ser_ready with nothing to send must not disturb the idle state
    ser_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check_output("idle_ready_cnt", bit_cnt, 0);
    check_output("idle_ready_valid", ser_valid, 0);
    next_cycle();

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Stall after the first bit of 1010 LSB-first
    push_seq(4'b0101, 4);
    ser_ready = 1'b1;
    apply_stimulus(4'b1010, 1'b0);
    @(negedge clk);
    check_output("stall_first_bit", ser_out, 0);
    next_cycle();
    ser_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("stall_ser_out", ser_out, 1);
      check_output("stall_cnt", bit_cnt, 3);
      check_output("stall_valid", ser_valid, 1);
      check_output("stall_mode", mode, 2'b00);
      next_cycle();
    end
    ser_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check_output("stall_done", done, 1);
    next_cycle();

    // Abort after two bits of 0111 LSB-first
    dc0 = done_count;
    push_seq(4'b1110, 2);
    apply_stimulus(4'b0111, 1'b0);
    repeat (2) next_cycle();
    abort = 1'b1;
    ser_ready = 1'b0;
    @(negedge clk);
    check_output("abort_done_low", done, 0);
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    check_output("abort_busy", busy, 0);
    check_output("abort_in_ready", in_ready, 1);
    check_output("abort_cnt", bit_cnt, 0);
    check_output("abort_valid", ser_valid, 0);
    repeat (2) next_cycle();
    check_output("abort_no_done", done_count, dc0);
    run_vector('{data: 4'b1001, msb: 1'b0, seq: 4'b1001, beat_mode: 2'b10});

    // Abort coinciding with the last beat: no done pulse
    dc0 = done_count;
    push_seq(4'b1011, 3);
    ser_ready = 1'b1;
    apply_stimulus(4'b1101, 1'b0);
    repeat (3) next_cycle();
    abort = 1'b1;
    @(negedge clk);
    check_output("lastabort_cnt", bit_cnt, 1);
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    check_output("lastabort_done", done, 0);
    check_output("lastabort_busy", busy, 0);
    check_output("lastabort_cnt0", bit_cnt, 0);
    next_cycle();
    check_output("lastabort_no_done", done_count, dc0);

    // Asynchronous reset mid-word
    push_seq(4'b1111, 1);
    ser_ready = 1'b1;
    apply_stimulus(4'b1111, 1'b0);
    next_cycle();
    ser_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_in_ready", in_ready, 1);
    check_output("arst_ser_valid", ser_valid, 0);
    check_output("arst_busy", busy, 0);
    check_output("arst_done", done, 0);
    check_output("arst_mode", mode, 2'b00);
    check_output("arst_ser_out", ser_out, 0);
    check_output("arst_bit_cnt", bit_cnt, 0);
    next_cycle();
    rst = 1'b1;
    run_vector('{data: 4'b0001, msb: 1'b0, seq: 4'b1000, beat_mode: 2'b10});

    // in_valid held high across two back-to-back words
    dc0 = done_count;
    n = 0;
    acc[0] = 0;
    acc[1] = 0;
    push_seq(4'b1100, 4);
    push_seq(4'b0011, 4);
    ser_ready    = 1'b1;
    in_valid     = 1'b1;
    in_data      = 4'b0011;
    in_msb_first = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_valid && in_ready && n < 2) begin
        acc[n] = cyc;
        n++;
      end
      next_cycle();
      if (n == 1) in_data = 4'b1100;
      if (n == 2) in_valid = 1'b0;
      if (done_count == dc0 + 2) break;
    end
    in_valid = 1'b0;
    repeat (3) next_cycle();
    check_output("b2b_accepts", n, 2);
    check_output("b2b_spacing", acc[1] - acc[0], 6);
    check_output("b2b_done_pulses", done_count - dc0, 2);

    check_output("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
